// File: rtl/mem_responder_pkg.sv
// Shared definitions for the load/store memory responder: word width, opcodes, FSM encoding.
package mem_responder_pkg;

  localparam int unsigned WORD = 16;

  // Processor opcodes that map onto req_write (LD -> 0, ST -> 1).
  localparam logic [3:0] LD = 4'h8;
  localparam logic [3:0] ST = 4'h9;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // An address is in range when no bit above the implemented width is set.
  function automatic logic addr_in_range(logic [WORD-1:0] addr, int unsigned addr_w);
    return (addr >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// LD/ST request/response channel between the processor (master) and the memory (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [WORD-1:0] req_addr;
  logic [WORD-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [WORD-1:0] rsp_rdata;
  logic            rsp_err;
  logic            busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port word store: synchronous write, combinational read.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD-1:0]   wdata,
  output logic [WORD-1:0]   rdata
);

  localparam int unsigned     Depth    = 1 << ADDR_W;
  localparam logic [WORD-1:0] InitWord = INIT_ZERO ? '0 : 'x;

  // Power-up contents only; reset never touches the store.
  logic [WORD-1:0] mem_q [Depth] = '{default: InitWord};

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding request, fixed latency, response held until consumed.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LATENCY   = 2,
  parameter bit          INIT_ZERO = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  mem_responder_if.slave bus
);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [WORD-1:0] addr_q, wdata_q;
  logic            write_q;
  logic [WORD-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            accept, enter_resp;
  logic [WORD-1:0] cur_addr, cur_wdata, mem_rdata;
  logic            cur_write, cur_ok, mem_we;

  // In IDLE the live request drives the store; afterwards the latched copy does.
  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_write = write_q;
    if (state_q == StIdle) begin
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_write = bus.req_write;
    end
  end

  assign cur_ok = addr_in_range(cur_addr, ADDR_W);
  assign accept = (state_q == StIdle) && bus.req_valid;
  // Stores commit on the accept edge; out-of-range stores are dropped.
  assign mem_we = accept && bus.req_write && cur_ok;

  mem_array #(
    .ADDR_W   (ADDR_W),
    .INIT_ZERO(INIT_ZERO)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (cur_addr[ADDR_W-1:0]),
    .wdata(cur_wdata),
    .rdata(mem_rdata)
  );

  // Next-state and latency countdown.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response payload captured on the RESP entry edge: store echo, load data or zero on error.
  always_comb begin
    err_d   = !cur_ok;
    rdata_d = '0;
    if (cur_write) begin
      rdata_d = cur_wdata;
    end else if (cur_ok) begin
      rdata_d = mem_rdata;
    end
  end

  // State, counter, request latch and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        write_q <= bus.req_write;
      end
      if (enter_resp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
